// File: rtl/regfile_2r1w_if.sv
// Decode/writeback side of the register file: one write port and two read ports.
// ADDR_W must match the one the register file derives from its DEPTH.
interface regfile_2r1w_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [ADDR_W-1:0] raddr0;
  logic [ADDR_W-1:0] raddr1;
  logic [WIDTH-1:0]  rdata0;
  logic [WIDTH-1:0]  rdata1;

  modport master (
    output we, waddr, wdata, raddr0, raddr1,
    input  rdata0, rdata1
  );

  modport slave (
    input  we, waddr, wdata, raddr0, raddr1,
    output rdata0, rdata1
  );
endinterface

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with optional r0 hardwiring, write forwarding
// and a registered read stage.
module regfile_2r1w #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0
) (
  input  logic           clk,
  input  logic           rst,
  regfile_2r1w_if.slave  bus
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              we_eff;
  logic [ADDR_W-1:0] ridx0, ridx1;
  logic [WIDTH-1:0]  mval0, mval1;
  logic [WIDTH-1:0]  rval0, rval1;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [WIDTH-1:0] sel_read(
    input logic [ADDR_W-1:0] a,
    input logic [WIDTH-1:0]  stored,
    input logic              wr,
    input logic [ADDR_W-1:0] wa,
    input logic [WIDTH-1:0]  wd
  );
    if (!in_range(a))                       return '0;
    else if (is_zero_reg(a))                return '0;
    else if ((BYPASS != 0) && wr && wa == a) return wd;
    else                                    return stored;
  endfunction

  assign we_eff = bus.we & ~rst & in_range(bus.waddr) & ~is_zero_reg(bus.waddr);

  // Out-of-range addresses are steered to entry 0 so mem is never indexed past DEPTH.
  assign ridx0 = in_range(bus.raddr0) ? bus.raddr0 : '0;
  assign ridx1 = in_range(bus.raddr1) ? bus.raddr1 : '0;
  assign mval0 = mem[ridx0];
  assign mval1 = mem[ridx1];

  assign rval0 = sel_read(bus.raddr0, mval0, we_eff, bus.waddr, bus.wdata);
  assign rval1 = sel_read(bus.raddr1, mval1, we_eff, bus.waddr, bus.wdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we_eff) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  if (READ_REG != 0) begin : g_rreg
    logic [WIDTH-1:0] q0, q1;

    always_ff @(posedge clk) begin
      if (rst) begin
        q0 <= '0;
        q1 <= '0;
      end else begin
        q0 <= rval0;
        q1 <= rval1;
      end
    end

    assign bus.rdata0 = q0;
    assign bus.rdata1 = q1;
  end else begin : g_comb
    assign bus.rdata0 = rval0;
    assign bus.rdata1 = rval1;
  end
endmodule

// File: tb/tb_regfile_2r1w.sv
// Drives four differently configured register files with one shared stimulus
// stream and checks each against an array-based model of the read/write rules.
module tb_regfile_2r1w;
  // k | DEPTH | ZERO_REG | BYPASS | READ_REG
  // 0 |  32   |    1     |   1    |    0
  // 1 |  24   |    0     |   0    |    0
  // 2 |  24   |    1     |   1    |    1
  // 3 |  32   |    0     |   0    |    1
  function automatic int dep_of(int k); return (k == 1 || k == 2) ? 24 : 32; endfunction
  function automatic int zr_of(int k);  return (k == 0 || k == 2) ? 1 : 0;   endfunction
  function automatic int bp_of(int k);  return (k == 0 || k == 2) ? 1 : 0;   endfunction
  function automatic int rr_of(int k);  return (k >= 2) ? 1 : 0;             endfunction

  logic        clk;
  logic        rst_d, we_d;
  logic [4:0]  waddr_d, ra0_d, ra1_d;
  logic [31:0] wdata_d;
  logic [31:0] obs [4][2];

  int total = 0;
  int bad   = 0;

  logic [31:0] mm [4][32];
  logic [31:0] mq [4][2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar k = 0; k < 4; k++) begin : g_dut
    regfile_2r1w_if #(.WIDTH(32), .ADDR_W(5)) bus ();
    assign bus.we     = we_d;
    assign bus.waddr  = waddr_d;
    assign bus.wdata  = wdata_d;
    assign bus.raddr0 = ra0_d;
    assign bus.raddr1 = ra1_d;
    assign obs[k][0]  = bus.rdata0;
    assign obs[k][1]  = bus.rdata1;

    regfile_2r1w #(
      .WIDTH(32), .DEPTH(dep_of(k)), .ZERO_REG(zr_of(k)),
      .BYPASS(bp_of(k)), .READ_REG(rr_of(k))
    ) u_dut (
      .clk (clk),
      .rst (rst_d),
      .bus (bus)
    );
  end

  function automatic logic m_weff(int k);
    return we_d && !rst_d && (int'(waddr_d) < dep_of(k)) && !(zr_of(k) != 0 && waddr_d == 0);
  endfunction

  function automatic logic [31:0] m_read(int k, logic [4:0] a);
    if (int'(a) >= dep_of(k)) return 32'h0;
    if (zr_of(k) != 0 && a == 0) return 32'h0;
    if (bp_of(k) != 0 && m_weff(k) && waddr_d == a) return wdata_d;
    return mm[k][a];
  endfunction

  function automatic logic [31:0] m_exp(int k, int p);
    if (rr_of(k) != 0) return mq[k][p];
    return m_read(k, (p == 0) ? ra0_d : ra1_d);
  endfunction

  // One clock edge: advance the model alongside the DUTs, then settle.
  task automatic step();
    logic [31:0] n0, n1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (rst_d) begin
        for (int i = 0; i < 32; i++) mm[k][i] = 32'h0;
        mq[k][0] = 32'h0;
        mq[k][1] = 32'h0;
      end else begin
        n0 = m_read(k, ra0_d);
        n1 = m_read(k, ra1_d);
        if (m_weff(k)) mm[k][waddr_d] = wdata_d;
        mq[k][0] = n0;
        mq[k][1] = n1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_d = 1'b1; we_d = 1'b1; waddr_d = 5'd3; wdata_d = $urandom;
    step();
    step();
    rst_d = 1'b0; we_d = 1'b0;
    for (int a = 0; a < 32; a++) begin
      ra0_d = 5'(a);
      ra1_d = 5'(31 - a);
      #1;
      for (int k = 0; k < 4; k++)
        for (int p = 0; p < 2; p++) begin
          total++;
          if (obs[k][p] !== 32'h0) begin
            bad++;
            $display("FAIL reset_read k=%0d p=%0d addr=%0d got=%h want=0", k, p, a, obs[k][p]);
          end
        end
      step();
    end
    we_d = 1'b1; waddr_d = 5'd5; wdata_d = 32'hDEADBEEF; ra0_d = 5'd5; ra1_d = 5'd5;
    step();
    we_d = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        total++;
        if (obs[k][p] !== 32'hDEADBEEF) begin
          bad++;
          $display("FAIL r5_comb k=%0d p=%0d got=%h want=deadbeef", k, p, obs[k][p]);
        end
      end
    step();
    for (int k = 2; k < 4; k++)
      for (int p = 0; p < 2; p++) begin
        total++;
        if (obs[k][p] !== 32'hDEADBEEF) begin
          bad++;
          $display("FAIL r5_reg k=%0d p=%0d got=%h want=deadbeef", k, p, obs[k][p]);
        end
      end
  endtask

  task automatic test_zero_reg();
    logic [31:0] want;
    we_d = 1'b1; waddr_d = 5'd0; wdata_d = 32'h12345678;
    step();
    we_d = 1'b0; ra0_d = 5'd0; ra1_d = 5'd0;
    step();
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < 2; p++) begin
        want = (zr_of(k) != 0) ? 32'h0 : 32'h12345678;
        total++;
        if (obs[k][p] !== want) begin
          bad++;
          $display("FAIL zero_reg k=%0d p=%0d got=%h want=%h", k, p, obs[k][p], want);
        end
      end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    we_d = 1'b1; waddr_d = 5'd7; wdata_d = 32'h1;
    step();
    wdata_d = 32'hA5A5A5A5; ra0_d = 5'd7; ra1_d = 5'd7;
    #1;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        want = (bp_of(k) != 0) ? 32'hA5A5A5A5 : 32'h1;
        total++;
        if (obs[k][p] !== want) begin
          bad++;
          $display("FAIL bypass_same k=%0d p=%0d got=%h want=%h", k, p, obs[k][p], want);
        end
      end
    step();
    we_d = 1'b0;
    #1;
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < 2; p++) begin
        want = (rr_of(k) == 0 || bp_of(k) != 0) ? 32'hA5A5A5A5 : 32'h1;
        total++;
        if (obs[k][p] !== want) begin
          bad++;
          $display("FAIL bypass_next k=%0d p=%0d got=%h want=%h", k, p, obs[k][p], want);
        end
      end
    step();
    for (int k = 2; k < 4; k++) begin
      total++;
      if (obs[k][0] !== 32'hA5A5A5A5 || obs[k][1] !== 32'hA5A5A5A5) begin
        bad++;
        $display("FAIL bypass_late k=%0d got=%h/%h want=a5a5a5a5", k, obs[k][0], obs[k][1]);
      end
    end
  endtask

  task automatic test_read_reg();
    for (int i = 1; i <= 3; i++) begin
      we_d = 1'b1; waddr_d = 5'(i); wdata_d = 32'h11 * i;
      step();
    end
    we_d = 1'b0; ra1_d = 5'd0;
    for (int i = 1; i <= 3; i++) begin
      ra0_d = 5'(i);
      #1;
      if (i > 1)
        for (int k = 2; k < 4; k++) begin
          total++;
          if (obs[k][0] !== 32'h11 * (i - 1)) begin
            bad++;
            $display("FAIL rreg_hold k=%0d i=%0d got=%h want=%h", k, i, obs[k][0], 32'h11 * (i - 1));
          end
        end
      step();
      for (int k = 2; k < 4; k++) begin
        total++;
        if (obs[k][0] !== 32'h11 * i) begin
          bad++;
          $display("FAIL rreg_seq k=%0d i=%0d got=%h want=%h", k, i, obs[k][0], 32'h11 * i);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    we_d = 1'b1; waddr_d = 5'd9; wdata_d = 32'hFF;
    step();
    rst_d = 1'b1; wdata_d = 32'h77; ra0_d = 5'd9; ra1_d = 5'd9;
    #1;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        total++;
        if (obs[k][p] !== 32'hFF) begin
          bad++;
          $display("FAIL rst_cycle k=%0d p=%0d got=%h want=ff", k, p, obs[k][p]);
        end
      end
    step();
    rst_d = 1'b0; we_d = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      for (int k = 0; k < 4; k++)
        for (int p = 0; p < 2; p++) begin
          total++;
          if (obs[k][p] !== 32'h0) begin
            bad++;
            $display("FAIL rst_after k=%0d p=%0d c=%0d got=%h want=0", k, p, c, obs[k][p]);
          end
        end
      step();
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] saved [32];
    for (int i = 1; i < 24; i++) begin
      we_d = 1'b1; waddr_d = 5'(i); wdata_d = $urandom; saved[i] = wdata_d;
      step();
    end
    waddr_d = 5'd30; wdata_d = 32'hCAFE; ra0_d = 5'd30; ra1_d = 5'd30;
    #1;
    total++;
    if (obs[1][0] !== 32'h0 || obs[1][1] !== 32'h0 || obs[0][0] !== 32'hCAFE) begin
      bad++;
      $display("FAIL oor_write got=%h/%h/%h want=0/0/cafe", obs[1][0], obs[1][1], obs[0][0]);
    end
    step();
    we_d = 1'b0;
    for (int i = 1; i < 24; i++) begin
      ra0_d = 5'(i); ra1_d = 5'd30;
      #1;
      total++;
      if (obs[1][0] !== saved[i] || obs[1][1] !== 32'h0 || obs[0][1] !== 32'hCAFE) begin
        bad++;
        $display("FAIL oor_comb i=%0d got=%h/%h/%h want=%h/0/cafe", i, obs[1][0], obs[1][1], obs[0][1], saved[i]);
      end
      step();
      total++;
      if (obs[2][0] !== saved[i] || obs[2][1] !== 32'h0 || obs[3][1] !== 32'hCAFE) begin
        bad++;
        $display("FAIL oor_reg i=%0d got=%h/%h/%h want=%h/0/cafe", i, obs[2][0], obs[2][1], obs[3][1], saved[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] want;
    for (int n = 0; n < 600; n++) begin
      rst_d   = ($urandom_range(0, 40) == 0);
      we_d    = 1'($urandom_range(0, 1));
      waddr_d = 5'($urandom_range(0, 31));
      wdata_d = $urandom;
      ra0_d   = ($urandom_range(0, 1) != 0) ? waddr_d : 5'($urandom_range(0, 31));
      ra1_d   = ($urandom_range(0, 2) == 0) ? ra0_d   : 5'($urandom_range(0, 31));
      #1;
      for (int k = 0; k < 4; k++)
        for (int p = 0; p < 2; p++) begin
          want = m_exp(k, p);
          total++;
          if (obs[k][p] !== want) begin
            bad++;
            $display("FAIL random n=%0d k=%0d p=%0d got=%h want=%h", n, k, p, obs[k][p], want);
          end
        end
      step();
    end
    rst_d = 1'b0; we_d = 1'b0;
  endtask

  initial begin
    rst_d = 1'b1; we_d = 1'b0; waddr_d = '0; wdata_d = '0; ra0_d = '0; ra1_d = '0;
    test_reset();
    test_zero_reg();
    test_bypass();
    test_read_reg();
    test_reset_mid();
    test_out_of_range();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
